// File: rtl/rom_dl_bridge.sv
// rom_dl_bridge: packs ioctl ROM download bytes into WORD_BYTES-wide words
// with byte enables, queues them in a small FIFO and writes them to memory
// over a req/ack port. Also generates rom_loaded and the core reset request.
// Optional build macro ROM_DL_CHECKSUM_EN adds dl_sum / dl_bytes outputs.
module rom_dl_bridge #(
   parameter int         WORD_BYTES = 2,
   parameter int         ADDR_W     = 25,
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] DL_INDEX   = 8'd0
) (
   input  logic                                 clk_sys,
   input  logic                                 reset_n,
   input  logic                                 dl_active,
   input  logic [7:0]                           dl_index,
   input  logic                                 dl_wr,
   input  logic [ADDR_W-1:0]                    dl_addr,
   input  logic [7:0]                           dl_data,
   input  logic                                 ext_reset,
   output logic                                 mem_req,
   input  logic                                 mem_ack,
   output logic [ADDR_W-$clog2(WORD_BYTES)-1:0] mem_addr,
   output logic [8*WORD_BYTES-1:0]              mem_din,
   output logic [WORD_BYTES-1:0]                mem_be,
   output logic                                 rom_loaded,
   output logic                                 core_reset,
   output logic                                 overflow,
   output logic                                 busy
`ifdef ROM_DL_CHECKSUM_EN
   ,
   output logic [15:0]                          dl_sum,
   output logic [ADDR_W-1:0]                    dl_bytes
`endif
);

   localparam int LW   = $clog2(WORD_BYTES);
   localparam int LS   = (LW > 0) ? LW : 1;
   localparam int WA_W = ADDR_W - LW;
   localparam int DW   = 8 * WORD_BYTES;
   localparam int PW   = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [WA_W-1:0]       addr;
      logic [DW-1:0]         data;
      logic [WORD_BYTES-1:0] be;
   } ent_t;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} st_t;

   // ---------------- input decode ----------------
   logic            dl_active_q;
   logic            acc, dl_fall;
   logic [LS-1:0]   lane;
   logic [WA_W-1:0] word;

   assign acc     = dl_wr & dl_active & (dl_index == DL_INDEX);
   assign dl_fall = dl_active_q & ~dl_active;
   assign word    = dl_addr[ADDR_W-1:LW];

   generate
      if (LW == 0) begin : g_lane1
         assign lane = '0;
      end else begin : g_laneN
         assign lane = dl_addr[LS-1:0];
      end
   endgenerate

   // ---------------- staging register ----------------
   logic                  stg_vld_q, stg_vld_d;
   logic                  stg_last_q, stg_last_d;
   logic [WA_W-1:0]       stg_addr_q, stg_addr_d;
   logic [DW-1:0]         stg_data_q, stg_data_d;
   logic [WORD_BYTES-1:0] stg_be_q, stg_be_d;
   logic                  push;

   // Staging leaves on: top lane written last cycle, a new word arriving,
   // or the end of the download.
   assign push = stg_vld_q & (stg_last_q | dl_fall | (acc & (word != stg_addr_q)));

   // Next staging contents: retire on push, then merge or freshly load the byte
   always_comb begin
      stg_vld_d  = stg_vld_q;
      stg_last_d = stg_last_q;
      stg_addr_d = stg_addr_q;
      stg_data_d = stg_data_q;
      stg_be_d   = stg_be_q;
      if (push) begin
         stg_vld_d  = 1'b0;
         stg_last_d = 1'b0;
         stg_be_d   = '0;
      end
      if (acc) begin
         if (!stg_vld_d) begin
            stg_addr_d = word;
            stg_data_d = '0;
            stg_be_d   = '0;
            stg_last_d = 1'b0;
         end
         stg_vld_d                    = 1'b1;
         stg_data_d[{lane, 3'b000} +: 8] = dl_data;
         stg_be_d[lane]               = 1'b1;
         if (lane == LS'(WORD_BYTES - 1)) stg_last_d = 1'b1;
      end
   end

   // Staging state registers
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         stg_vld_q   <= 1'b0;
         stg_last_q  <= 1'b0;
         stg_addr_q  <= '0;
         stg_data_q  <= '0;
         stg_be_q    <= '0;
         dl_active_q <= 1'b0;
      end else begin
         stg_vld_q   <= stg_vld_d;
         stg_last_q  <= stg_last_d;
         stg_addr_q  <= stg_addr_d;
         stg_data_q  <= stg_data_d;
         stg_be_q    <= stg_be_d;
         dl_active_q <= dl_active;
      end
   end

   // ---------------- word FIFO ----------------
   ent_t          fifo_q [FIFO_DEPTH];
   logic [PW-1:0] wptr_q, rptr_q;
   logic [PW:0]   cnt_q;
   logic          overflow_q;
   st_t           st_q;
   logic          pop, full, wr_ok, drop;

   // The request register takes the head when the FSM leaves IDLE, so the
   // FIFO slot frees as soon as the word is in flight.
   assign pop   = (st_q == S_IDLE) && (cnt_q != '0);
   assign full  = (cnt_q == (PW+1)'(FIFO_DEPTH));
   assign wr_ok = push & (~full | pop);
   assign drop  = push & full & ~pop;

   // FIFO storage, written only on an accepted push
   always_ff @(posedge clk_sys) begin
      if (wr_ok) fifo_q[wptr_q] <= '{addr: stg_addr_q, data: stg_data_q, be: stg_be_q};
   end

   // FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (wr_ok) wptr_q <= wptr_q + 1'b1;
         if (pop)   rptr_q <= rptr_q + 1'b1;
         case ({wr_ok, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
         if (drop) overflow_q <= 1'b1;
      end
   end

   // ---------------- memory FSM ----------------
   logic                  mem_req_q;
   logic [WA_W-1:0]       mem_addr_q;
   logic [DW-1:0]         mem_din_q;
   logic [WORD_BYTES-1:0] mem_be_q;

   // IDLE -> REQ (hold until ack) -> GAP (one low cycle) -> IDLE
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         st_q       <= S_IDLE;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         mem_be_q   <= '0;
      end else begin
         case (st_q)
            S_IDLE: if (pop) begin
               mem_addr_q <= fifo_q[rptr_q].addr;
               mem_din_q  <= fifo_q[rptr_q].data;
               mem_be_q   <= fifo_q[rptr_q].be;
               mem_req_q  <= 1'b1;
               st_q       <= S_REQ;
            end
            S_REQ: if (mem_ack) begin
               mem_req_q <= 1'b0;
               st_q      <= S_GAP;
            end
            S_GAP:   st_q <= S_IDLE;
            default: st_q <= S_IDLE;
         endcase
      end
   end

   assign busy = stg_vld_q | (cnt_q != '0) | (st_q != S_IDLE);

   // ---------------- load status / core reset ----------------
   logic seen_q, rom_loaded_q, core_reset_q;

   // rom_loaded needs at least one accepted byte, download ended and all drained
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         seen_q       <= 1'b0;
         rom_loaded_q <= 1'b0;
         core_reset_q <= 1'b1;
      end else begin
         if (acc) seen_q <= 1'b1;
         if (seen_q & ~dl_active & ~busy) rom_loaded_q <= 1'b1;
         core_reset_q <= ext_reset | dl_active | busy | ~rom_loaded_q;
      end
   end

   assign mem_req    = mem_req_q;
   assign mem_addr   = mem_addr_q;
   assign mem_din    = mem_din_q;
   assign mem_be     = mem_be_q;
   assign rom_loaded = rom_loaded_q;
   assign core_reset = core_reset_q;
   assign overflow   = overflow_q;

`ifdef ROM_DL_CHECKSUM_EN
   logic [15:0]       sum_q;
   logic [ADDR_W-1:0] bytes_q;
   logic              dl_rise;

   assign dl_rise = dl_active & ~dl_active_q;

   // Running byte sum and count; a new download restarts both
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         sum_q   <= '0;
         bytes_q <= '0;
      end else if (dl_rise) begin
         sum_q   <= acc ? {8'h00, dl_data} : 16'h0000;
         bytes_q <= acc ? ADDR_W'(1) : '0;
      end else if (acc) begin
         sum_q   <= sum_q + {8'h00, dl_data};
         bytes_q <= bytes_q + 1'b1;
      end
   end

   assign dl_sum   = sum_q;
   assign dl_bytes = bytes_q;
`endif

endmodule

// File: tb/tb_rom_dl_bridge.sv
// Bench for rom_dl_bridge (WORD_BYTES=2, ADDR_W=25, FIFO_DEPTH=4, DL_INDEX=0).
module tb_rom_dl_bridge;

   logic        clk = 1'b0;
   logic        reset_n, dl_active, dl_wr, ext_reset, mem_ack;
   logic [7:0]  dl_index, dl_data;
   logic [24:0] dl_addr;
   logic        mem_req, rom_loaded, core_reset, overflow, busy;
   logic [23:0] mem_addr;
   logic [15:0] mem_din;
   logic [1:0]  mem_be;
`ifdef ROM_DL_CHECKSUM_EN
   logic [15:0] dl_sum;
   logic [24:0] dl_bytes;
`endif

   logic rsp_ack = 1'b0, man_ack = 1'b0;
   assign mem_ack = rsp_ack | man_ack;

   always #5 clk = ~clk;

   rom_dl_bridge #(.WORD_BYTES(2), .ADDR_W(25), .FIFO_DEPTH(4), .DL_INDEX(8'd0)) dut (
      .clk_sys(clk), .reset_n(reset_n), .dl_active(dl_active), .dl_index(dl_index),
      .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .ext_reset(ext_reset),
      .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_be(mem_be), .rom_loaded(rom_loaded), .core_reset(core_reset),
      .overflow(overflow), .busy(busy)
`ifdef ROM_DL_CHECKSUM_EN
      , .dl_sum(dl_sum), .dl_bytes(dl_bytes)
`endif
   );

   int checks = 0, errors = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   // ---------------- scoreboard + ack responder ----------------
   typedef struct { logic [23:0] a; logic [15:0] d; logic [1:0] b; } exp_t;
   exp_t sb_q[$];
   bit   ack_en = 1'b0;
   int   ack_wait = 0, wait_cnt = 0;
   bit   saw_req = 1'b0;

   always @(negedge clk) begin
      if (mem_req) saw_req = 1'b1;
      if (rsp_ack) rsp_ack = 1'b0;
      else if (ack_en && mem_req) begin
         if (wait_cnt >= ack_wait) begin
            exp_t e;
            wait_cnt = 0;
            if (sb_q.size() == 0) chk("sb_unexpected_req", {8'h0, mem_addr}, 32'hFFFFFFFF);
            else begin
               e = sb_q.pop_front();
               chk("sb_addr", {8'h0, mem_addr}, {8'h0, e.a});
               chk("sb_din",  {16'h0, mem_din}, {16'h0, e.d});
               chk("sb_be",   {30'h0, mem_be},  {30'h0, e.b});
            end
            rsp_ack = 1'b1;
         end else wait_cnt++;
      end
   end

   // ---------------- helpers ----------------
   task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
      dl_wr = 1'b1; dl_addr = a; dl_data = d;
      @(negedge clk);
      dl_wr = 1'b0;
   endtask

   task automatic wait_idle(input string nm, input int max);
      bit ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (!busy && !mem_req && sb_q.size() == 0) begin ok = 1'b1; break; end
      end
      chk(nm, {31'h0, ok}, 32'h1);
   endtask

   task automatic wait_req(input string nm, input int max);
      bit ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (mem_req) begin ok = 1'b1; break; end
      end
      chk(nm, {31'h0, ok}, 32'h1);
   endtask

   // ---------------- vectors: single-word downloads closed by a flush ----------------
   typedef struct {
      logic [24:0] a0; logic [7:0] d0; bit two; logic [24:0] a1; logic [7:0] d1;
      logic [23:0] ea; logic [15:0] ed; logic [1:0] eb;
   } vec_t;
   vec_t vt[5];

   initial begin
      #200000;
      $display("FAIL watchdog_timeout got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{25'h0000000, 8'h11, 1'b1, 25'h0000001, 8'h22, 24'h000000, 16'h2211, 2'b11};
      vt[1] = '{25'h0000005, 8'hAB, 1'b0, 25'h0000000, 8'h00, 24'h000002, 16'hAB00, 2'b10};
      vt[2] = '{25'h0000006, 8'h3C, 1'b0, 25'h0000000, 8'h00, 24'h000003, 16'h003C, 2'b01};
      vt[3] = '{25'h0000020, 8'h01, 1'b1, 25'h0000020, 8'h02, 24'h000010, 16'h0002, 2'b01};
      vt[4] = '{25'h1FFFFFF, 8'hEE, 1'b0, 25'h0000000, 8'h00, 24'hFFFFFF, 16'hEE00, 2'b10};

      reset_n = 1'b0; dl_active = 1'b0; dl_index = 8'd0; dl_wr = 1'b0;
      dl_addr = '0; dl_data = '0; ext_reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_mem_req",    {31'h0, mem_req},    32'h0);
      chk("rst_mem_be",     {30'h0, mem_be},     32'h0);
      chk("rst_rom_loaded", {31'h0, rom_loaded}, 32'h0);
      chk("rst_overflow",   {31'h0, overflow},   32'h0);
      chk("rst_busy",       {31'h0, busy},       32'h0);
      chk("rst_core_reset", {31'h0, core_reset}, 32'h1);
      reset_n = 1'b1;
      @(negedge clk);

      // foreign index: nothing accepted, no load
      saw_req = 1'b0; dl_index = 8'd1; dl_active = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 8; i++) wr_byte(25'(i), 8'h5A);
      dl_active = 1'b0;
      repeat (10) @(negedge clk);
      chk("idx_no_req",     {31'h0, saw_req},    32'h0);
      chk("idx_rom_loaded", {31'h0, rom_loaded}, 32'h0);
      chk("idx_busy",       {31'h0, busy},       32'h0);
      dl_index = 8'd0;

      // full word, manual ack after 5 held cycles, GAP/busy timing
      dl_active = 1'b1;
      @(negedge clk);
      wr_byte(25'h0, 8'h11);
      wr_byte(25'h1, 8'h22);
      wait_req("t1_req_timeout", 20);
      chk("t1_addr", {8'h0, mem_addr}, 32'h0);
      chk("t1_din",  {16'h0, mem_din}, 32'h2211);
      chk("t1_be",   {30'h0, mem_be},  32'h3);
      repeat (5) @(negedge clk);
      chk("t1_req_held", {31'h0, mem_req}, 32'h1);
      chk("t1_din_held", {16'h0, mem_din}, 32'h2211);
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      chk("t1_req_gap",    {31'h0, mem_req},    32'h0);
      chk("t1_busy_gap",   {31'h0, busy},       32'h1);
      chk("t1_creset_gap", {31'h0, core_reset}, 32'h1);
      @(negedge clk);
      chk("t1_busy_idle",  {31'h0, busy},       32'h0);
      dl_active = 1'b0;
      repeat (3) @(negedge clk);
      chk("t1_rom_loaded",  {31'h0, rom_loaded}, 32'h1);
      chk("t1_creset_ext",  {31'h0, core_reset}, 32'h1);
      ext_reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("t1_creset_fall", {31'h0, core_reset}, 32'h0);

      // table-driven downloads, each closed by dl_active falling
      ack_en = 1'b1; ack_wait = 5;
      for (int v = 0; v < 5; v++) begin
         dl_active = 1'b1;
         @(negedge clk);
         sb_q.push_back('{vt[v].ea, vt[v].ed, vt[v].eb});
         wr_byte(vt[v].a0, vt[v].d0);
         if (vt[v].two) wr_byte(vt[v].a1, vt[v].d1);
         dl_active = 1'b0;
         wait_idle("vec_drain", 100);
         chk("vec_rom_loaded", {31'h0, rom_loaded}, 32'h1);
      end

      // overflow: 6 words against a stalled port, then drain
      ack_en = 1'b0; ack_wait = 1;
      dl_active = 1'b1;
      @(negedge clk);
      for (int w = 0; w < 5; w++) sb_q.push_back('{24'(w), {8'(2*w+2), 8'(2*w+1)}, 2'b11});
      for (int i = 0; i < 12; i++) wr_byte(25'(i), 8'(i + 1));
      repeat (4) @(negedge clk);
      chk("ovf_set", {31'h0, overflow}, 32'h1);
      ack_en = 1'b1;
      dl_active = 1'b0;
      wait_idle("ovf_drain", 200);
      chk("ovf_sticky", {31'h0, overflow}, 32'h1);

      // reset while a request is outstanding
      ack_en = 1'b0;
      dl_active = 1'b1;
      @(negedge clk);
      wr_byte(25'h40, 8'h5A);
      wr_byte(25'h41, 8'hA5);
      wait_req("rst_req_timeout", 20);
      reset_n = 1'b0; dl_active = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      chk("mrst_req",        {31'h0, mem_req},    32'h0);
      chk("mrst_busy",       {31'h0, busy},       32'h0);
      chk("mrst_rom_loaded", {31'h0, rom_loaded}, 32'h0);
      chk("mrst_overflow",   {31'h0, overflow},   32'h0);
      chk("mrst_core_reset", {31'h0, core_reset}, 32'h1);
      saw_req = 1'b0;
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      repeat (5) @(negedge clk);
      chk("mrst_ack_ignored", {31'h0, saw_req}, 32'h0);
      chk("mrst_busy_after",  {31'h0, busy},    32'h0);

`ifdef ROM_DL_CHECKSUM_EN
      // 258 x 0xFF: sum wraps to 0x00FE
      ack_en = 1'b1; ack_wait = 0;
      dl_active = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 258; i++) begin
         if (i % 2 == 1) sb_q.push_back('{24'(i / 2), 16'hFFFF, 2'b11});
         wr_byte(25'(i), 8'hFF);
         repeat (3) @(negedge clk);
      end
      chk("cks_sum",   {16'h0, dl_sum},  32'h00FE);
      chk("cks_bytes", {7'h0, dl_bytes}, 32'd258);
      dl_active = 1'b0;
      wait_idle("cks_drain", 200);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
